// File: rtl/s_axi_regfile_pkg.sv
// s_axi_regfile_pkg: shared response codes, FSM state types and index helpers
// for the AXI register bank.
package s_axi_regfile_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    // Lowest address bit that selects a register (byte offset bits sit below it).
    function automatic int idx_lsb(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // Number of address bits that select a register.
    function automatic int idx_width(input int num_regs);
        return (num_regs < 2) ? 1 : $clog2(num_regs);
    endfunction

    // True when a decoded index maps onto an implemented register.
    function automatic logic idx_in_range(input int idx, input int num_regs);
        return idx < num_regs;
    endfunction

endpackage

// File: rtl/s_axi_regfile_strb_merge.sv
// regfile_strb_merge: byte-lane merge of a new write word into the old
// register contents under the AXI write strobe.
module regfile_strb_merge #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   old_word,
    input  logic [DATA_W-1:0]   new_word,
    input  logic [DATA_W/8-1:0] strb,
    output logic [DATA_W-1:0]   merged
);

    // Replace only the byte lanes whose strobe bit is set.
    always_comb begin
        merged = old_word;
        for (int i = 0; i < DATA_W / 8; i++) begin
            if (strb[i]) merged[i*8 +: 8] = new_word[i*8 +: 8];
        end
    end

endmodule

// File: rtl/s_axi_regfile.sv
// s_axi_regfile: single-beat AXI slave register bank with a hardware-side
// view of every register and a per-register write pulse.
// Optional feature: define AXI_REGFILE_OOR_ERR_EN to answer out-of-range
// accesses with SLVERR instead of aliasing the index modulo 2^IDX_W.
//
// Write FSM
//   state  | meaning
//   W_IDLE | waiting for AW and/or W
//   W_ADDR | address/id held, waiting for W
//   W_DATA | data/strobe held, waiting for AW
//   W_RESP | bvalid high, waiting for bready
// Read FSM
//   state  | meaning
//   R_IDLE | arready high, waiting for AR
//   R_DATA | rvalid high, waiting for rready
module s_axi_regfile
    import s_axi_regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8,
    parameter int ID_W     = 4,
    parameter int ADDR_W   = 32
) (
    input  logic                       clk,
    input  logic                       areset,
    input  logic [ID_W-1:0]            awid_i,
    input  logic [ADDR_W-1:0]          awaddr_i,
    input  logic                       awvalid_i,
    output logic                       awready_o,
    input  logic [DATA_W-1:0]          wdata_i,
    input  logic [DATA_W/8-1:0]        wstrb_i,
    input  logic                       wlast_i,
    input  logic                       wvalid_i,
    output logic                       wready_o,
    output logic [ID_W-1:0]            bid_o,
    output logic [1:0]                 bresp_o,
    output logic                       bvalid_o,
    input  logic                       bready_i,
    input  logic [ID_W-1:0]            arid_i,
    input  logic [ADDR_W-1:0]          araddr_i,
    input  logic                       arvalid_i,
    output logic                       arready_o,
    output logic [ID_W-1:0]            rid_o,
    output logic [DATA_W-1:0]          rdata_o,
    output logic [1:0]                 rresp_o,
    output logic                       rlast_o,
    output logic                       rvalid_o,
    input  logic                       rready_i,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic [NUM_REGS-1:0]        wr_pulse_o
);

    localparam int LSB    = idx_lsb(DATA_W);
    localparam int IDX_W  = idx_width(NUM_REGS);
    localparam int STRB_W = DATA_W / 8;

    wr_state_t           wr_state, wr_next;
    rd_state_t           rd_state, rd_next;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] wr_pulse_q;
    logic [ADDR_W-1:0]   aw_addr_q;
    logic [ID_W-1:0]     aw_id_q, bid_q, rid_q;
    logic [DATA_W-1:0]   w_data_q, rdata_q;
    logic [STRB_W-1:0]   w_strb_q;
    logic [1:0]          bresp_q, rresp_q;

    logic                aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_W-1:0]   commit_addr;
    logic [ID_W-1:0]     commit_id;
    logic [DATA_W-1:0]   commit_data, w_old, w_merged;
    logic [STRB_W-1:0]   commit_strb;
    logic [IDX_W-1:0]    w_idx, r_idx;
    logic                w_ok, r_ok;
    logic [1:0]          w_resp, r_resp;
    logic                unused_bits;

    // Ready/valid come straight from state flops, so no input reaches them combinationally.
    assign awready_o = (wr_state == W_IDLE) || (wr_state == W_DATA);
    assign wready_o  = (wr_state == W_IDLE) || (wr_state == W_ADDR);
    assign bvalid_o  = (wr_state == W_RESP);
    assign arready_o = (rd_state == R_IDLE);
    assign rvalid_o  = (rd_state == R_DATA);
    assign rlast_o   = 1'b1;
    assign bid_o     = bid_q;
    assign bresp_o   = bresp_q;
    assign rid_o     = rid_q;
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;
    assign wr_pulse_o = wr_pulse_q;

    assign aw_hs = awvalid_i && awready_o;
    assign w_hs  = wvalid_i && wready_o;
    assign ar_hs = arvalid_i && arready_o;

    // A held half of the write comes from the capture flops, the other from the bus.
    assign commit_addr = (wr_state == W_ADDR) ? aw_addr_q : awaddr_i;
    assign commit_id   = (wr_state == W_ADDR) ? aw_id_q   : awid_i;
    assign commit_data = (wr_state == W_DATA) ? w_data_q  : wdata_i;
    assign commit_strb = (wr_state == W_DATA) ? w_strb_q  : wstrb_i;

    assign w_idx = commit_addr[LSB +: IDX_W];
    assign r_idx = araddr_i[LSB +: IDX_W];

`ifdef AXI_REGFILE_OOR_ERR_EN
    assign w_ok   = idx_in_range(int'(w_idx), NUM_REGS) && ((commit_addr >> (LSB + IDX_W)) == '0);
    assign r_ok   = idx_in_range(int'(r_idx), NUM_REGS) && ((araddr_i >> (LSB + IDX_W)) == '0);
    assign w_resp = w_ok ? RESP_OKAY : RESP_SLVERR;
    assign r_resp = r_ok ? RESP_OKAY : RESP_SLVERR;
`else
    assign w_ok   = idx_in_range(int'(w_idx), NUM_REGS);
    assign r_ok   = idx_in_range(int'(r_idx), NUM_REGS);
    assign w_resp = RESP_OKAY;
    assign r_resp = RESP_OKAY;
`endif

    // Byte offsets and wlast carry no information for single-beat word access.
    assign unused_bits = ^{wlast_i, commit_addr, araddr_i};

    assign w_old = regs_q[w_idx];

    regfile_strb_merge #(.DATA_W(DATA_W)) u_strb_merge (
        .old_word (w_old),
        .new_word (commit_data),
        .strb     (commit_strb),
        .merged   (w_merged)
    );

    // Write FSM next state; commit fires on the edge where the second half arrives.
    always_comb begin
        wr_next = wr_state;
        commit  = 1'b0;
        case (wr_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit  = 1'b1;
                    wr_next = W_RESP;
                end else if (aw_hs) begin
                    wr_next = W_ADDR;
                end else if (w_hs) begin
                    wr_next = W_DATA;
                end
            end
            W_ADDR: if (w_hs) begin
                commit  = 1'b1;
                wr_next = W_RESP;
            end
            W_DATA: if (aw_hs) begin
                commit  = 1'b1;
                wr_next = W_RESP;
            end
            W_RESP: if (bready_i) wr_next = W_IDLE;
            default: wr_next = W_IDLE;
        endcase
    end

    // Write state, capture flops, register array and write pulse.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            wr_state   <= W_IDLE;
            aw_addr_q  <= '0;
            aw_id_q    <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bid_q      <= '0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
        end else begin
            wr_state   <= wr_next;
            wr_pulse_q <= '0;
            if (aw_hs) begin
                aw_addr_q <= awaddr_i;
                aw_id_q   <= awid_i;
            end
            if (w_hs) begin
                w_data_q <= wdata_i;
                w_strb_q <= wstrb_i;
            end
            if (commit) begin
                bid_q   <= commit_id;
                bresp_q <= w_resp;
                if (w_ok) begin
                    regs_q[w_idx]     <= w_merged;
                    wr_pulse_q[w_idx] <= 1'b1;
                end
            end
        end
    end

    // Read FSM next state.
    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE:  if (ar_hs) rd_next = R_DATA;
            R_DATA:  if (rready_i) rd_next = R_IDLE;
            default: rd_next = R_IDLE;
        endcase
    end

    // Read state and response capture; sampling regs_q here returns the pre-write value.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            rd_state <= R_IDLE;
            rdata_q  <= '0;
            rid_q    <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            rd_state <= rd_next;
            if (ar_hs) begin
                rdata_q <= r_ok ? regs_q[r_idx] : '0;
                rid_q   <= arid_i;
                rresp_q <= r_resp;
            end
        end
    end

    // Flatten the register array for the hardware-side view.
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_o
        assign regs_o[k*DATA_W +: DATA_W] = regs_q[k];
    end

endmodule

// File: tb/tb_s_axi_regfile.sv
// tb_s_axi_regfile: directed bench with write/read response scoreboards.
module tb_s_axi_regfile;

    localparam int DW = 32;
    localparam int NR = 8;
    localparam int IW = 4;
    localparam int AW = 32;

    logic            clk = 1'b0;
    logic            areset = 1'b0;
    logic [IW-1:0]   awid = '0;
    logic [AW-1:0]   awaddr = '0;
    logic            awvalid = 1'b0;
    logic            awready;
    logic [DW-1:0]   wdata = '0;
    logic [DW/8-1:0] wstrb = '0;
    logic            wlast = 1'b1;
    logic            wvalid = 1'b0;
    logic            wready;
    logic [IW-1:0]   bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready = 1'b0;
    logic [IW-1:0]   arid = '0;
    logic [AW-1:0]   araddr = '0;
    logic            arvalid = 1'b0;
    logic            arready;
    logic [IW-1:0]   rid;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready = 1'b0;
    logic [NR*DW-1:0] regs;
    logic [NR-1:0]   wr_pulse;

    typedef struct { logic [IW-1:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; } r_exp_t;
    b_exp_t bq[$];
    r_exp_t rq[$];

    int n_cmp = 0;
    int n_fail = 0;

`ifdef AXI_REGFILE_OOR_ERR_EN
    localparam logic [1:0]    OOR_RESP  = 2'b10;
    localparam logic [DW-1:0] OOR_WORD0 = 32'h0;
    localparam logic [NR-1:0] OOR_PULSE = 8'h00;
`else
    localparam logic [1:0]    OOR_RESP  = 2'b00;
    localparam logic [DW-1:0] OOR_WORD0 = 32'hCAFE_0001;
    localparam logic [NR-1:0] OOR_PULSE = 8'h01;
`endif

    always #5 clk = ~clk;

    s_axi_regfile #(.DATA_W(DW), .NUM_REGS(NR), .ID_W(IW), .ADDR_W(AW)) dut (
        .clk(clk), .areset(areset),
        .awid_i(awid), .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready),
        .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast), .wvalid_i(wvalid), .wready_o(wready),
        .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
        .arid_i(arid), .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready),
        .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast), .rvalid_o(rvalid),
        .rready_i(rready),
        .regs_o(regs), .wr_pulse_o(wr_pulse)
    );

    function automatic logic [DW-1:0] word(input int k);
        return regs[k*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic b_collect(input string tag);
        b_exp_t e;
        int n = 0;
        while (bvalid !== 1'b1 && n < 20) begin tick(); n++; end
        if (bvalid !== 1'b1) begin
            check({tag, "_b_timeout"}, {63'd0, bvalid}, 64'd1);
        end else if (bq.size() == 0) begin
            check({tag, "_b_unexpected"}, 64'd1, 64'd0);
        end else begin
            e = bq.pop_front();
            check({tag, "_bid"}, 64'(bid), 64'(e.id));
            check({tag, "_bresp"}, 64'(bresp), 64'(e.resp));
            bready = 1'b1;
            tick();
            bready = 1'b0;
            check({tag, "_b_done"}, 64'(bvalid), 64'd0);
        end
    endtask

    task automatic r_collect(input string tag);
        r_exp_t e;
        int n = 0;
        while (rvalid !== 1'b1 && n < 20) begin tick(); n++; end
        if (rvalid !== 1'b1) begin
            check({tag, "_r_timeout"}, {63'd0, rvalid}, 64'd1);
        end else if (rq.size() == 0) begin
            check({tag, "_r_unexpected"}, 64'd1, 64'd0);
        end else begin
            e = rq.pop_front();
            check({tag, "_rid"}, 64'(rid), 64'(e.id));
            check({tag, "_rdata"}, 64'(rdata), 64'(e.data));
            check({tag, "_rresp"}, 64'(rresp), 64'(e.resp));
            rready = 1'b1;
            tick();
            rready = 1'b0;
            check({tag, "_r_done"}, 64'(rvalid), 64'd0);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_awready"}, 64'(awready), 64'd1);
        check({tag, "_wready"}, 64'(wready), 64'd1);
        check({tag, "_arready"}, 64'(arready), 64'd1);
        check({tag, "_bvalid"}, 64'(bvalid), 64'd0);
        check({tag, "_rvalid"}, 64'(rvalid), 64'd0);
        check({tag, "_rlast"}, 64'(rlast), 64'd1);
        check({tag, "_bid"}, 64'(bid), 64'd0);
        check({tag, "_rdata"}, 64'(rdata), 64'd0);
        check({tag, "_regs_zero"}, 64'(regs != '0), 64'd0);
        check({tag, "_wr_pulse"}, 64'(wr_pulse), 64'd0);
    endtask

    initial begin
        #12;
        check_reset_values("rst");
        @(posedge clk);
        #1 areset = 1'b1;
        tick();

        // AW and W together
        awvalid = 1; awid = 4'd3; awaddr = 32'h08;
        wvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        bq.push_back('{id: 4'd3, resp: 2'b00});
        tick();
        awvalid = 0; wvalid = 0;
        check("t1_bvalid", 64'(bvalid), 64'd1);
        check("t1_word2", 64'(word(2)), 64'hDEADBEEF);
        check("t1_pulse", 64'(wr_pulse), 64'h04);
        check("t1_awready_resp", 64'(awready), 64'd0);
        check("t1_wready_resp", 64'(wready), 64'd0);
        tick();
        check("t1_pulse_gone", 64'(wr_pulse), 64'h00);
        check("t1_bvalid_held", 64'(bvalid), 64'd1);
        b_collect("t1");

        // W three cycles before AW, low byte only
        wvalid = 1; wdata = 32'h000000AA; wstrb = 4'h1;
        tick();
        wvalid = 0;
        for (int i = 0; i < 2; i++) begin
            check("t2_awready_wdata", 64'(awready), 64'd1);
            check("t2_wready_wdata", 64'(wready), 64'd0);
            check("t2_no_bvalid", 64'(bvalid), 64'd0);
            tick();
        end
        awvalid = 1; awid = 4'd1; awaddr = 32'h08;
        bq.push_back('{id: 4'd1, resp: 2'b00});
        tick();
        awvalid = 0;
        check("t2_bvalid", 64'(bvalid), 64'd1);
        check("t2_word2", 64'(word(2)), 64'hDEADBEAA);
        check("t2_pulse", 64'(wr_pulse), 64'h04);
        b_collect("t2");

        // Read with rready held low for 4 cycles
        arvalid = 1; arid = 4'd5; araddr = 32'h08;
        rq.push_back('{id: 4'd5, data: 32'hDEADBEAA, resp: 2'b00});
        tick();
        arvalid = 0;
        check("t3_arready_busy", 64'(arready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            check("t3_rvalid_hold", 64'(rvalid), 64'd1);
            check("t3_rdata_hold", 64'(rdata), 64'hDEADBEAA);
            check("t3_rid_hold", 64'(rid), 64'd5);
            check("t3_rlast", 64'(rlast), 64'd1);
            tick();
        end
        r_collect("t3");

        // Read and write word 3 on the same edge
        arvalid = 1; arid = 4'd2; araddr = 32'h0C;
        awvalid = 1; awid = 4'd4; awaddr = 32'h0C;
        wvalid = 1; wdata = 32'h00001234; wstrb = 4'hF;
        rq.push_back('{id: 4'd2, data: 32'h0, resp: 2'b00});
        bq.push_back('{id: 4'd4, resp: 2'b00});
        tick();
        arvalid = 0; awvalid = 0; wvalid = 0;
        b_collect("t4w");
        r_collect("t4r");
        arvalid = 1; arid = 4'd6; araddr = 32'h0C;
        rq.push_back('{id: 4'd6, data: 32'h00001234, resp: 2'b00});
        tick();
        arvalid = 0;
        r_collect("t4r2");

        // Zero strobe: no data change, still OKAY and a pulse
        awvalid = 1; awid = 4'd9; awaddr = 32'h04;
        wvalid = 1; wdata = 32'hFFFFFFFF; wstrb = 4'h0;
        bq.push_back('{id: 4'd9, resp: 2'b00});
        tick();
        awvalid = 0; wvalid = 0;
        check("t5_word1", 64'(word(1)), 64'h0);
        check("t5_pulse", 64'(wr_pulse), 64'h02);
        b_collect("t5");

        // Address 0x40: aliases to word 0, or SLVERR with the range check enabled
        awvalid = 1; awid = 4'd7; awaddr = 32'h40;
        wvalid = 1; wdata = 32'hCAFE0001; wstrb = 4'hF;
        bq.push_back('{id: 4'd7, resp: OOR_RESP});
        tick();
        awvalid = 0; wvalid = 0;
        check("t6_word0", 64'(word(0)), 64'(OOR_WORD0));
        check("t6_pulse", 64'(wr_pulse), 64'(OOR_PULSE));
        check("t6_word2_kept", 64'(word(2)), 64'hDEADBEAA);
        b_collect("t6w");
        arvalid = 1; arid = 4'd8; araddr = 32'h40;
        rq.push_back('{id: 4'd8, data: OOR_WORD0, resp: OOR_RESP});
        tick();
        arvalid = 0;
        r_collect("t6r");

        // Reset while in W_ADDR and R_DATA
        awvalid = 1; awid = 4'hA; awaddr = 32'h10;
        arvalid = 1; arid = 4'hB; araddr = 32'h08;
        tick();
        awvalid = 0; arvalid = 0;
        check("t7_in_waddr", 64'(wready), 64'd1);
        check("t7_in_waddr_aw", 64'(awready), 64'd0);
        check("t7_in_rdata", 64'(rvalid), 64'd1);
        #2 areset = 1'b0;
        #1;
        check_reset_values("t7_rst");
        @(posedge clk);
        #1 areset = 1'b1;
        tick();
        awvalid = 1; awid = 4'hC; awaddr = 32'h14;
        wvalid = 1; wdata = 32'h00000F0F; wstrb = 4'hF;
        bq.push_back('{id: 4'hC, resp: 2'b00});
        tick();
        awvalid = 0; wvalid = 0;
        check("t7_word5", 64'(word(5)), 64'h00000F0F);
        check("t7_pulse", 64'(wr_pulse), 64'h20);
        b_collect("t7");

        check("sb_b_empty", 64'(bq.size()), 64'd0);
        check("sb_r_empty", 64'(rq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/s_axi_regfile.md
# s_axi_regfile

Parametrised AXI slave register bank: NUM_REGS registers of DATA_W bits, single-beat write and read transactions, byte-addressed, with ID echo, byte strobes and an optional out-of-range error response. Write address and data may arrive in either order or together. A hardware-side view exposes every register and a per-register write pulse, so the bank can drive counter control and status logic directly.

## Interface
- DATA_W, 32: register and bus data width; 32 or 64.
- NUM_REGS, 8: number of registers; ≥2.
- ID_W, 4: AXI ID width.
- ADDR_W, 32: AXI address width.
- clk  in  1  clock, all logic on rising edge.
- areset  in  1  asynchronous, active-low reset.
- awid_i/awaddr_i/awvalid_i  in  ID_W/ADDR_W/1; awready_o  out  1.
- wdata_i/wstrb_i/wlast_i/wvalid_i  in  DATA_W/DATA_W/8/1/1; wready_o  out  1; wlast_i ignored (single beat).
- bid_o/bresp_o/bvalid_o  out  ID_W/2/1; bready_i  in  1.
- arid_i/araddr_i/arvalid_i  in  ID_W/ADDR_W/1; arready_o  out  1.
- rid_o/rdata_o/rresp_o/rlast_o/rvalid_o  out  ID_W/DATA_W/2/1/1; rready_i  in  1.
- regs_o  out  NUM_REGS*DATA_W  all registers; register k at bits [k*DATA_W +: DATA_W].
- wr_pulse_o  out  NUM_REGS  one-cycle pulse on the cycle after register k is written.

## Operation
- Index = addr[LSB +: IDX_W], LSB = log2(DATA_W/8), IDX_W = clog2(NUM_REGS). Address bits below LSB are ignored.
- Write FSM states: W_IDLE, W_ADDR (address held), W_DATA (data and strobe held), W_RESP.
  - awready_o = 1 in W_IDLE and W_DATA.
  - wready_o = 1 in W_IDLE and W_ADDR.
  - Both ready outputs are 0 in W_RESP.
- Write transitions:
  - W_IDLE: AW only → W_ADDR; W only → W_DATA; both in the same cycle → commit → W_RESP.
  - W_ADDR + W handshake → commit → W_RESP; W_DATA + AW handshake → commit → W_RESP.
  - W_RESP with bready_i → W_IDLE.
- Commit: byte lane i of the register is updated only where wstrb_i[i] (or the held strobe) is 1. wstrb = 0 still responds OKAY and still pulses wr_pulse_o.
- bid_o = captured awid_i.
- Read FSM states: R_IDLE (arready_o = 1), R_DATA (rvalid_o = 1).
  - On AR handshake: rdata_o, rid_o and rresp_o are registered → R_DATA.
  - R_DATA with rready_i → R_IDLE.
- rlast_o is constant 1.
- A read and a write to the same index on the same edge: the read returns the pre-write value.
- Reset (asserted at any time, including mid-transaction) abandons in-flight transactions and returns to reset values:
  - awready_o = wready_o = arready_o = 1.
  - bvalid_o = rvalid_o = 0.
  - bid_o, bresp_o, rid_o, rresp_o, rdata_o, regs_o, wr_pulse_o all 0.
  - rlast_o = 1.

## Timing
- Write: bvalid_o rises 1 cycle after the edge on which the second of AW/W handshakes. The register update is visible on regs_o in that same cycle.
- Read: rvalid_o rises 1 cycle after the AR handshake.
- bvalid_o, bid_o, bresp_o are held stable until bready_i. rvalid_o, rdata_o, rid_o, rresp_o are held stable until rready_i.
- Peak throughput: one write per 2 cycles and one read per 2 cycles, both with ready tied high. Read and write channels operate fully concurrently.
- No combinational path from any input to any ready or valid output.

## Configuration
- AXI_REGFILE_OOR_ERR_EN defined: an index ≥ NUM_REGS, or any set address bit above LSB+IDX_W, is out of range.
  - Out-of-range write: dropped, no wr_pulse_o, bresp_o = SLVERR (2'b10).
  - Out-of-range read: rdata_o = 0, rresp_o = SLVERR.
- Macro undefined: the index is taken modulo 2^IDX_W; an index ≥ NUM_REGS reads 0 and drops writes. Responses are always OKAY (2'b00).

## Structure
- Package s_axi_regfile_pkg holds:
  - response constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;
  - write-state enum wr_state_t and read-state enum rd_state_t;
  - function clog2-based index helpers.
- Sub-module regfile_strb_merge (combinational): takes old word, new data and strobe; returns the merged word. It is instantiated once, on the commit path.

## Test plan
- Reset, then AW(id 3, addr 0x08) and W(0xDEADBEEF, strb 0xF) in the same cycle → next cycle bvalid_o = 1, bid_o = 3, bresp_o = 0; regs_o word 2 = 0xDEADBEEF; wr_pulse_o = 8'b0000_0100 for one cycle.
- W(0x000000AA, strb 0x1) three cycles before AW(addr 0x08) → word 2 = 0xDEADBEAA. awready_o stays 1 while in W_DATA; wready_o = 0 until the response.
- AR(id 5, addr 0x08) with rready_i held low for 4 cycles → rvalid_o = 1 and rdata_o = 0xDEADBEAA stable throughout, rid_o = 5, rlast_o = 1. Handshake completes on the cycle rready_i rises.
- Read and write to addr 0x0C on the same edge (old value 0, new 0x1234) → read returns 0; the next read returns 0x1234.
- With the macro defined, write and read addr 0x40 (NUM_REGS = 8) → bresp_o = 2'b10, no register changes, rresp_o = 2'b10, rdata_o = 0. Without the macro, the same write returns OKAY and lands in word 0.
- areset deasserted-low while in W_ADDR and R_DATA → all outputs return to reset values asynchronously. The next full write completes normally.
